winograd_tile_buffer: RTL
=========================

Name: winograd_tile_buffer

Overview:
Upstream feeder for the combinational Winograd F(2x2,3x3) engine. It accepts a raster-order 8-bit pixel stream for one IMG_H x IMG_W frame and stores it in a rotating 4-row buffer. From that buffer it emits overlapping 4x4 input tiles at stride 2 with a valid/ready handshake. Each tile feeds the engine's 16 input bytes directly; each 2x2 engine output maps to output pixels (2*tile_row..+1, 2*tile_col..+1).

Parameters:
IMG_W, 8, frame width in pixels; even, >=4
IMG_H, 8, frame height in pixels; even, >=4
DW, 8, pixel width in bits

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE
pix_in  in  DW  pixel data, raster order
pix_valid  in  1  pix_in valid
pix_ready  out  1  buffer accepts pixel this cycle
tile_out  out  16*DW  tile; byte [DW*(4*r+c) +: DW] = tile row r, col c (r=0 top, c=0 left)
tile_valid  out  1  tile_out valid
tile_ready  in  1  downstream accepts tile
tile_row  out  $clog2(IMG_H/2)  tile vertical index (band)
tile_col  out  $clog2(IMG_W/2)  tile horizontal index
frame_done  out  1  one-cycle pulse after the last tile is accepted
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is one clock, one synchronous active-high reset, fixed. On rst: state=IDLE; pix_ready=0, tile_valid=0, frame_done=0, busy=0; tile_row=0, tile_col=0; base slot=0; write counters=0. Buffer contents are not cleared. Reset mid-frame abandons the frame with no partial output.
- Storage: 4 physical row slots of IMG_W x DW. Logical tile row r reads slot (base+r) mod 4.
- FSM states: IDLE, FILL, EMIT, DONE.
- IDLE: start -> FILL with rows_needed=4, write slot=base. start is ignored in every other state.
- FILL:
  - pix_ready=1.
  - Each pix_valid&&pix_ready writes the pixel at the current column and increments the column; at IDLE_W-1 the column wraps to 0 and the slot advances mod 4.
  - On the edge that accepts the last required pixel, state goes to EMIT. tile_valid first rises in the next cycle (registered).
- EMIT:
  - pix_ready=0, tile_valid=1.
  - tile_out is a combinational read of the slots at columns 2*tile_col..2*tile_col+3. It is stable while tile_valid && !tile_ready.
  - On handshake with tile_col < IMG_W/2-2: tile_col++.
  - On handshake with tile_col = IMG_W/2-2 and tile_row < IMG_H/2-2: tile_col=0, tile_row++, base=(base+2) mod 4, rows_needed=2, write slot=(new base+2) mod 4, state goes to FILL. The two retained rows are reused as the top half of the next band.
  - On handshake at the last tile (tile_row=IMG_H/2-2): state goes to DONE.
- DONE: frame_done=1 for exactly one cycle; next state IDLE; tile_row/tile_col/base reset to 0.
- Tile counts:
  - Tiles per band = IMG_W/2-1.
  - Bands = IMG_H/2-1.
  - Total pixels accepted per frame = IMG_W*IMG_H.
- Pixels offered while pix_ready=0 are not consumed; the upstream source holds them.
- tile_ready asserted while tile_valid=0 has no effect.
- Throughput: one tile per cycle under continuous tile_ready within a band. No overlap of FILL and EMIT, by design.

Decomposition:
- Package winograd_pkg: DW default, TILE_N=4, STRIDE=2, state enum {IDLE, FILL, EMIT, DONE}, and a tile byte-index function idx(r,c)=4*r+c.
- Sub-module winograd_row_store holds the 4 x IMG_W register array.
  - One write port: slot, column, data, enable.
  - Combinational 4x4 window read given base and column offset, with rotation applied internally.
- FSM and counters stay in winograd_tile_buffer.

Test Plan:
- 8x8 frame, pixel = 16*row+col, tile_ready=1 -> first tile bytes 0..15 = 00,01,02,03,10,11,12,13,20..23,30..33. The tile appears the cycle after pixel 0x37 is accepted.
- Same frame -> tile (0,1) = 02..05,12..15,22..25,32..35. Tile (1,0) = 20..23,...,50..53 and is preceded by exactly 16 pixel accepts. 9 tiles total; frame_done pulses once, 1 cycle after the 9th handshake; busy then drops.
- Hold tile_ready=0 for 5 cycles on tile (0,1) -> tile_valid stays 1, tile_out and indices unchanged, pix_ready=0 throughout.
- Random pix_valid gaps during FILL -> tile contents identical to the gap-free run; no pixel dropped or duplicated.
- Assert rst during EMIT of tile (1,1) -> next cycle: tile_valid=0, busy=0, indices 0. A new start plus a full frame reproduces the first-frame tiles exactly.
- IMG_W=IMG_H=4 build -> exactly one tile (bytes = all 16 pixels in order), then frame_done. A start pulse while busy is ignored, with no state change.

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared types and constants for the Winograd F(2x2,3x3) tile buffer:
// tile geometry, FSM state encoding and the tile byte-index helper.
package winograd_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int TILE_N     = 4;
    localparam int STRIDE     = 2;
    localparam int SLOTS      = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        EMIT,
        DONE
    } state_e;

    // Byte position of tile element (r, c) inside the flattened 4x4 tile.
    function automatic int idx(input int r, input int c);
        return TILE_N * r + c;
    endfunction

endpackage

// File: rtl/winograd_tile_buffer_if.sv
// Pixel-in / tile-out handshake bundle between a raster source, the tile
// buffer and the downstream Winograd engine.
interface winograd_tile_buffer_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = winograd_pkg::DW_DEFAULT
);

    localparam int TR_W  = $clog2(IMG_H / 2);
    localparam int TC_W  = $clog2(IMG_W / 2);
    localparam int TILE_W = winograd_pkg::TILE_N * winograd_pkg::TILE_N * DW;

    logic              start;
    logic [DW-1:0]     pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [TILE_W-1:0] tile_out;
    logic              tile_valid;
    logic              tile_ready;
    logic [TR_W-1:0]   tile_row;
    logic [TC_W-1:0]   tile_col;
    logic              frame_done;
    logic              busy;

    modport master (
        output start, pix_in, pix_valid, tile_ready,
        input  pix_ready, tile_out, tile_valid, tile_row, tile_col, frame_done, busy
    );

    modport slave (
        input  start, pix_in, pix_valid, tile_ready,
        output pix_ready, tile_out, tile_valid, tile_row, tile_col, frame_done, busy
    );

endinterface

// File: rtl/winograd_row_store.sv
// Four rotating pixel-row slots with a single write port and a combinational
// 4x4 window read; the window's top row is slot rd_base_i.
module winograd_row_store
    import winograd_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int DW    = DW_DEFAULT,
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic                        clk,
    input  logic                        wr_en_i,
    input  logic [1:0]                  wr_slot_i,
    input  logic [COL_W-1:0]            wr_col_i,
    input  logic [DW-1:0]               wr_data_i,
    input  logic [1:0]                  rd_base_i,
    input  logic [COL_W-1:0]            rd_col_i,
    output logic [TILE_N*TILE_N*DW-1:0] window_o
);

    logic [DW-1:0] mem_q [SLOTS][IMG_W];

    // NOTE: no reset on the pixel array; every location a tile reads has been
    // written during FILL first, so its power-up contents are never observed.
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_slot_i][wr_col_i] <= wr_data_i;
        end
    end

    // NOTE: a default assignment first keeps this block latch-free even if a
    // loop bound or index is later edited.
    always_comb begin
        window_o = '0;
        for (int r = 0; r < TILE_N; r++) begin
            for (int c = 0; c < TILE_N; c++) begin
                window_o[DW*idx(r, c) +: DW] = mem_q[rd_base_i + 2'(r)][rd_col_i + COL_W'(c)];
            end
        end
    end

endmodule

// File: rtl/winograd_tile_buffer.sv
// Raster-to-tile front end for the Winograd F(2x2,3x3) engine: buffers four
// pixel rows and emits overlapping 4x4 tiles at stride 2, band by band.
module winograd_tile_buffer
    import winograd_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    winograd_tile_buffer_if.slave bus
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int TR_W  = $clog2(IMG_H / 2);
    localparam int TC_W  = $clog2(IMG_W / 2);

    localparam logic [COL_W-1:0] LAST_PIX_COL  = COL_W'(IMG_W - 1);
    localparam logic [TC_W-1:0]  LAST_TILE_COL = TC_W'(IMG_W / 2 - 2);
    localparam logic [TR_W-1:0]  LAST_TILE_ROW = TR_W'(IMG_H / 2 - 2);

    state_e           state_q;
    logic [TR_W-1:0]  tile_row_q;
    logic [TC_W-1:0]  tile_col_q;
    logic [1:0]       base_q;
    logic [1:0]       wr_slot_q;
    logic [COL_W-1:0] wr_col_q;
    logic [2:0]       rows_left_q;
    logic             pix_ready_q;
    logic             tile_valid_q;
    logic             frame_done_q;
    logic             busy_q;

    logic             pix_fire;
    logic             tile_fire;
    logic             last_pix;
    logic [1:0]       base_d;
    logic [COL_W-1:0] rd_col;

    assign pix_fire  = bus.pix_valid && pix_ready_q;
    assign tile_fire = bus.tile_ready && tile_valid_q;
    assign last_pix  = (rows_left_q == 3'd1) && (wr_col_q == LAST_PIX_COL);
    assign base_d    = base_q + 2'(STRIDE);
    assign rd_col    = COL_W'(STRIDE * tile_col_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tile_row_q   <= '0;
            tile_col_q   <= '0;
            base_q       <= '0;
            wr_slot_q    <= '0;
            wr_col_q     <= '0;
            rows_left_q  <= '0;
            pix_ready_q  <= 1'b0;
            tile_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q     <= FILL;
                        rows_left_q <= 3'd4;
                        wr_slot_q   <= base_q;
                        wr_col_q    <= '0;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                FILL: begin
                    if (pix_fire) begin
                        if (wr_col_q == LAST_PIX_COL) begin
                            wr_col_q    <= '0;
                            wr_slot_q   <= wr_slot_q + 2'd1;
                            rows_left_q <= rows_left_q - 3'd1;
                        end else begin
                            wr_col_q <= wr_col_q + COL_W'(1);
                        end
                        if (last_pix) begin
                            state_q      <= EMIT;
                            pix_ready_q  <= 1'b0;
                            tile_valid_q <= 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (tile_fire) begin
                        if (tile_col_q != LAST_TILE_COL) begin
                            tile_col_q <= tile_col_q + TC_W'(1);
                        end else if (tile_row_q != LAST_TILE_ROW) begin
                            // Bottom two rows stay put as the next band's top half;
                            // the two slots after them are refilled.
                            tile_col_q   <= '0;
                            tile_row_q   <= tile_row_q + TR_W'(1);
                            base_q       <= base_d;
                            wr_slot_q    <= base_d + 2'(STRIDE);
                            wr_col_q     <= '0;
                            rows_left_q  <= 3'(STRIDE);
                            state_q      <= FILL;
                            tile_valid_q <= 1'b0;
                            pix_ready_q  <= 1'b1;
                        end else begin
                            state_q      <= DONE;
                            tile_valid_q <= 1'b0;
                            frame_done_q <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    tile_row_q <= '0;
                    tile_col_q <= '0;
                    base_q     <= '0;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    winograd_row_store #(
        .IMG_W (IMG_W),
        .DW    (DW)
    ) u_store (
        .clk       (clk),
        .wr_en_i   (pix_fire),
        .wr_slot_i (wr_slot_q),
        .wr_col_i  (wr_col_q),
        .wr_data_i (bus.pix_in),
        .rd_base_i (base_q),
        .rd_col_i  (rd_col),
        .window_o  (bus.tile_out)
    );

    assign bus.pix_ready  = pix_ready_q;
    assign bus.tile_valid = tile_valid_q;
    assign bus.tile_row   = tile_row_q;
    assign bus.tile_col   = tile_col_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

    // A presented tile must not move until the engine takes it.
    assert property (@(posedge clk) disable iff (rst)
        tile_valid_q && !bus.tile_ready |=> tile_valid_q && $stable(bus.tile_out)
            && $stable(tile_row_q) && $stable(tile_col_q));

    assert property (@(posedge clk) disable iff (rst) !(pix_ready_q && tile_valid_q));

endmodule
